de2_i2c_write_engine: RTL and testbench

//   Bit-level I2C master for the DE2 A/V configuration path. Serialises one 24-bit

---
 rtl/de2_i2c_write_engine_if.sv | 11 +
 rtl/de2_i2c_write_engine.sv | 129 ++++++++++++
 tb/tb_de2_i2c_write_engine.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/de2_i2c_write_engine_if.sv
// rtl/de2_i2c_write_engine_if.sv - DATA/GO/END handshake between config sequencer and I2C engine
interface de2_i2c_write_engine_if;
  logic [23:0] iDATA;
  logic        iGO;
  logic        oEND;
  logic        oACK_ERR;
  logic        oBUSY;

  modport master (output iDATA, iGO, input oEND, oACK_ERR, oBUSY);
  modport slave  (input iDATA, iGO, output oEND, oACK_ERR, oBUSY);
endinterface

// File: rtl/de2_i2c_write_engine.sv
// rtl/de2_i2c_write_engine.sv - bit-level I2C write master for the DE2 A/V config path
module de2_i2c_write_engine #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  de2_i2c_write_engine_if.slave  bus,
  output logic                   I2C_SCLK,
  inout  wire                    I2C_SDAT
);
  localparam int DIV   = CLK_FREQ / (4 * I2C_FREQ);
  localparam int CNT_W = $clog2(DIV);

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} stateT;

  stateT       state, nState;
  logic [1:0]  phase, nPhase;
  logic [3:0]  bitCnt, nBit;
  logic [1:0]  byteCnt, nByte;
  logic [23:0] shreg, nShreg;
  logic [CNT_W-1:0] cnt;
  logic        ackErr, nAckErr;
  logic        endR, busyR, sdaLow;
  logic        sclNext, sdaLowNext;
  logic        tick;

  assign tick = (state != IDLE) && (state != DONE) && (cnt == CNT_W'(DIV - 1));

  assign I2C_SDAT     = sdaLow ? 1'b0 : 1'bz;
  assign bus.oEND     = endR;
  assign bus.oBUSY    = busyR;
  assign bus.oACK_ERR = ackErr;

  always_comb begin
    nState  = state;
    nPhase  = phase;
    nBit    = bitCnt;
    nByte   = byteCnt;
    nShreg  = shreg;
    nAckErr = ackErr;
    unique case (state)
      IDLE: if (bus.iGO) begin
        nState  = START;
        nPhase  = 2'd0;
        nShreg  = bus.iDATA;
        nAckErr = 1'b0;
      end
      START: if (tick) begin
        nPhase = phase + 2'd1;
        if (phase == 2'd3) begin
          nState = BITS;
          nBit   = 4'd0;
          nByte  = 2'd0;
        end
      end
      BITS: if (tick) begin
        nPhase = phase + 2'd1;
        // SDA sampled raw: by the end of p2 it has been stable for two ticks of SCL high
        if (phase == 2'd2 && bitCnt == 4'd8 && I2C_SDAT)
          nAckErr = 1'b1;
        if (phase == 2'd3) begin
          if (bitCnt == 4'd8) begin
            nBit = 4'd0;
            if (byteCnt == 2'd2) nState = STOP;
            else                 nByte  = byteCnt + 2'd1;
          end else begin
            nBit   = bitCnt + 4'd1;
            nShreg = {shreg[22:0], 1'b0};
          end
        end
      end
      STOP: if (tick) begin
        nPhase = phase + 2'd1;
        if (phase == 2'd3) nState = DONE;
      end
      DONE: if (!bus.iGO) nState = IDLE;
      default: nState = IDLE;
    endcase

    // pin levels are derived from the next state so SCL/SDA come straight off flops
    sclNext    = 1'b1;
    sdaLowNext = 1'b0;
    unique case (nState)
      START: begin
        sclNext    = (nPhase != 2'd3);
        sdaLowNext = nPhase[1];
      end
      BITS: begin
        sclNext    = (nPhase == 2'd1) || (nPhase == 2'd2);
        sdaLowNext = (nBit != 4'd8) && !nShreg[23];
      end
      STOP: begin
        sclNext    = (nPhase != 2'd0);
        sdaLowNext = (nPhase != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      phase    <= 2'd0;
      bitCnt   <= 4'd0;
      byteCnt  <= 2'd0;
      shreg    <= 24'd0;
      cnt      <= '0;
      ackErr   <= 1'b0;
      endR     <= 1'b0;
      busyR    <= 1'b0;
      sdaLow   <= 1'b0;
      I2C_SCLK <= 1'b1;
    end else begin
      state    <= nState;
      phase    <= nPhase;
      bitCnt   <= nBit;
      byteCnt  <= nByte;
      shreg    <= nShreg;
      ackErr   <= nAckErr;
      endR     <= (nState == DONE);
      busyR    <= (nState != IDLE);
      sdaLow   <= sdaLowNext;
      I2C_SCLK <= sclNext;
      if (state == IDLE || state == DONE || tick) cnt <= '0;
      else                                        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_de2_i2c_write_engine.sv
// tb/tb_de2_i2c_write_engine.sv - scoreboard bench for the I2C write engine
module tb_de2_i2c_write_engine;
  localparam int DIV = 5;
  localparam int LAT = 116 * DIV + 1;

  typedef struct {
    logic [23:0] data;
    logic        ackErr;
    int          endCyc;
  } expT;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic scl;
  wire  sdat;
  logic slaveDrive = 1'b0;
  logic [2:0] nackMask = 3'b000;
  int   cyc = 0;
  int   nChecks = 0;
  int   nFail = 0;
  expT  sbq[$];

  de2_i2c_write_engine_if ifc();

  de2_i2c_write_engine #(.CLK_FREQ(400), .I2C_FREQ(20)) dut (
    .iCLK     (clk),
    .iRST_N   (rstN),
    .bus      (ifc),
    .I2C_SCLK (scl),
    .I2C_SDAT (sdat)
  );

  assign sdat = slaveDrive ? 1'b0 : 1'bz;
  pullup (sdat);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: decodes the bus, models the slave ACK and scores each END
  logic        sclPrev = 1'b1, sdaPrev = 1'b1, endPrev = 1'b0, inXfer = 1'b0;
  int          bitPos = 0, starts = 0, stops = 0, highLen = 0;
  logic [23:0] decoded = 24'd0;

  always @(negedge clk) begin
    if (!rstN) begin
      sclPrev = scl; sdaPrev = sdat; endPrev = 1'b0; inXfer = 1'b0;
      bitPos = 0; starts = 0; stops = 0; highLen = 0; slaveDrive = 1'b0;
    end else begin
      if (sclPrev && scl && sdaPrev && !sdat) begin
        starts++; bitPos = 0; decoded = 24'd0; inXfer = 1'b1;
      end else if (sclPrev && scl && !sdaPrev && sdat) begin
        stops++; inXfer = 1'b0;
      end
      if (!sclPrev && scl && inXfer && bitPos < 27) begin
        if (bitPos % 9 != 8) decoded = {decoded[22:0], sdat};
        bitPos++;
      end
      if (scl) highLen++;
      if (sclPrev && !scl) begin
        if (inXfer && bitPos > 0) check("scl_high_width", highLen, 2 * DIV);
        highLen = 0;
        slaveDrive = inXfer && (bitPos % 9 == 8) && !nackMask[bitPos / 9];
      end
      if (!endPrev && ifc.oEND) begin
        check("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          expT e;
          e = sbq.pop_front();
          check("bytes", decoded, e.data);
          check("ack_err", ifc.oACK_ERR, e.ackErr);
          check("end_cycle", cyc, e.endCyc);
          check("bit_slots", bitPos, 27);
          check("start_count", starts, 1);
          check("stop_count", stops, 1);
        end
        starts = 0; stops = 0;
      end
      sclPrev = scl; sdaPrev = sdat; endPrev = ifc.oEND;
    end
  end

  task automatic startXfer(input logic [23:0] d, input logic [2:0] m);
    expT e;
    @(negedge clk);
    e.data = d; e.ackErr = |m; e.endCyc = cyc + LAT;
    sbq.push_back(e);
    nackMask = m; ifc.iDATA = d; ifc.iGO = 1'b1;
  endtask

  task automatic waitEnd();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      seen = ifc.oEND;
    end
    check("end_seen", seen, 1);
  endtask

  task automatic dropGo();
    @(negedge clk);
    ifc.iGO = 1'b0;
    @(negedge clk);
    check("end_low_after_go", ifc.oEND, 0);
    check("idle_not_busy", ifc.oBUSY, 0);
  endtask

  initial begin
    int sclLows, endLows;
    ifc.iDATA = 24'd0;
    ifc.iGO   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1);
    check("rst_sda", sdat, 1);
    check("rst_end", ifc.oEND, 0);
    check("rst_busy", ifc.oBUSY, 0);
    check("rst_ack_err", ifc.oACK_ERR, 0);
    rstN = 1'b1;

    // all bytes acked
    startXfer(24'h34_001A, 3'b000);
    @(negedge clk);
    check("busy_after_go", ifc.oBUSY, 1);
    waitEnd();
    dropGo();

    // NACK on second byte, then iGO held in DONE
    startXfer(24'h40_1741, 3'b010);
    waitEnd();
    sclLows = 0; endLows = 0;
    repeat (200) begin
      @(negedge clk);
      if (!scl) sclLows++;
      if (!ifc.oEND) endLows++;
    end
    check("hold_no_scl_low", sclLows, 0);
    check("hold_end_high", endLows, 0);
    check("hold_busy", ifc.oBUSY, 1);
    check("hold_ack_err_kept", ifc.oACK_ERR, 1);
    dropGo();

    // iDATA/iGO disturbed mid-transfer
    startXfer(24'hA5_5AC3, 3'b000);
    @(negedge clk);
    check("ack_err_cleared", ifc.oACK_ERR, 0);
    repeat (40) @(negedge clk);
    ifc.iDATA = 24'hFF_FFFF; ifc.iGO = 1'b0;
    repeat (20) @(negedge clk);
    ifc.iDATA = 24'h00_0000; ifc.iGO = 1'b1;
    waitEnd();
    dropGo();

    // reset mid-transfer, then a clean transfer
    @(negedge clk);
    ifc.iDATA = 24'h12_3456; ifc.iGO = 1'b1;
    repeat (300) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("abort_scl", scl, 1);
    check("abort_sda", sdat, 1);
    check("abort_busy", ifc.oBUSY, 0);
    check("abort_end", ifc.oEND, 0);
    ifc.iGO = 1'b0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    startXfer(24'h5A_0F81, 3'b100);
    waitEnd();
    dropGo();

    repeat (5) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
